alu_pipe: RTL and testbench

- Parametrised, handshaked successor to the combinational 4-op ALU.
- Executes 8 operations on WIDTH-bit operands behind valid/ready input and output interfaces, with a registered result and status flags.
- Single-cycle ops issue back-to-back. MUL runs as an iterative shift-add over WIDTH cycles and returns the full double-width product.
- Sits between the operand issue stage and the writeback stage of the datapath.

---
 rtl/alu_pipe.sv | 168 ++++++++++++++++
 tb/tb_alu_pipe.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Handshaked 8-op ALU with a registered result stage; MUL runs as an unsigned
// shift-add over WIDTH cycles and returns the full double-width product.
module alu_pipe #(
    parameter int WIDTH        = 32,
    parameter int OPCODE_WIDTH = 3,
    parameter int CNT_WIDTH    = $clog2(WIDTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [WIDTH-1:0]        op1,
    input  logic [WIDTH-1:0]        op2,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        result,
    output logic [WIDTH-1:0]        result_hi,
    output logic                    flag_zero,
    output logic                    flag_carry,
    output logic                    flag_ovf
);

    typedef enum logic [1:0] {IDLE, MUL_BUSY, MUL_DONE} state_t;

    localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_MUL  = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_NAND = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_AND  = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_OR   = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OP_XOR  = OPCODE_WIDTH'(6);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]       mplier_q, mplier_d;
    logic [2*WIDTH-1:0]     acc_q, acc_d;
    logic                   out_valid_q, out_valid_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic [WIDTH-1:0]       result_hi_q, result_hi_d;
    logic                   zero_q, zero_d;
    logic                   carry_q, carry_d;
    logic                   ovf_q, ovf_d;

    logic                   out_free;
    logic [WIDTH:0]         sum, diff;
    logic [WIDTH-1:0]       alu_res;
    logic                   alu_c, alu_v;

    assign out_free   = !out_valid_q || out_ready;
    assign in_ready   = (state_q == IDLE) && out_free;
    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign result_hi  = result_hi_q;
    assign flag_zero  = zero_q;
    assign flag_carry = carry_q;
    assign flag_ovf   = ovf_q;

    // Extra top bit of diff is the unsigned borrow.
    always_comb begin
        sum     = {1'b0, op1} + {1'b0, op2};
        diff    = {1'b0, op1} - {1'b0, op2};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (op1[WIDTH-1] != op2[WIDTH-1]) && (diff[WIDTH-1] != op1[WIDTH-1]);
            end
            OP_NAND: alu_res = ~(op1 & op2);
            OP_AND:  alu_res = op1 & op2;
            OP_OR:   alu_res = op1 | op2;
            OP_XOR:  alu_res = op1 ^ op2;
            default: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    if (opcode == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, op1};
                        mplier_d = op2;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = MUL_BUSY;
                    end else begin
                        result_d    = alu_res;
                        result_hi_d = '0;
                        zero_d      = (alu_res == '0);
                        carry_d     = alu_c;
                        ovf_d       = alu_v;
                        out_valid_d = 1'b1;
                    end
                end
            end
            MUL_BUSY: begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_WIDTH'(WIDTH - 1))
                    state_d = MUL_DONE;
            end
            MUL_DONE: begin
                // Product waits here until the output register can take it.
                if (out_free) begin
                    {result_hi_d, result_d} = acc_q;
                    zero_d      = (acc_q == '0);
                    carry_d     = 1'b0;
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe at WIDTH=8: directed scenarios plus random traffic, all
// results scored against an arithmetic model through an accept/consume queue.
module tb_alu_pipe;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   opcode = '0;
    logic [W-1:0] op1 = '0, op2 = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result, result_hi;
    logic         flag_zero, flag_carry, flag_ovf;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .op1(op1), .op2(op2),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_hi(result_hi),
        .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_ovf(flag_ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] res;
        logic         z, c, v;
    } exp_t;

    int n_chk  = 0;
    int n_pass = 0;
    exp_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    endtask

    function automatic int sgn(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    // Reference semantics in plain integer arithmetic.
    function automatic exp_t model(input int op, input int a, input int b);
        exp_t e;
        int r, s, p;
        e = '0;
        r = 0;
        case (op)
            0: begin r = a + b; e.c = (r > 255); s = sgn(a) + sgn(b); e.v = (s > 127 || s < -128); end
            1: begin r = a - b; e.c = (a < b);   s = sgn(a) - sgn(b); e.v = (s > 127 || s < -128); end
            2: begin
                p = a * b;
                e.res = 8'(p % 256);
                e.hi  = 8'(p / 256);
                e.z   = (p == 0);
                return e;
            end
            3: r = ~(a & b);
            4: r = a & b;
            5: r = a | b;
            6: r = a ^ b;
            default: r = (sgn(a) < sgn(b)) ? 1 : 0;
        endcase
        e.res = 8'(r & 255);
        e.z   = (e.res == 0);
        return e;
    endfunction

    function automatic logic [31:0] outs();
        return 32'({result_hi, result, flag_zero, flag_carry, flag_ovf});
    endfunction

    // Scoreboard: outputs sampled at negedge, pop on consume before push on accept.
    always @(negedge clk) begin
        if (!rst_n) sb_q.delete();
        else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) check("sb_extra", 32'(sb_q.size()), 32'd1);
                else check("sb_result", outs(), 32'(sb_q.pop_front()));
            end
            if (in_valid && in_ready) sb_q.push_back(model(int'(opcode), int'(op1), int'(op2)));
        end
    end

    // Present an op and return 1ns after the edge that accepts it.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int t = 0;
        in_valid = 1'b1; opcode = op; op1 = a; op2 = b;
        @(negedge clk);
        while (!in_ready && t < 100) begin @(negedge clk); t++; end
        if (!in_ready) check("issue_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    logic [W-1:0] corner [4] = '{8'h00, 8'h7F, 8'h80, 8'hFF};

    function automatic logic [W-1:0] rnd_op();
        return ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
    endfunction

    initial begin
        int n;
        // Reset state
        #12;
        check("rst_outs", {31'd0, out_valid} | outs(), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // ADD FF+01: latency 1, zero and carry set
        out_ready = 1'b1;
        issue(3'd0, 8'hFF, 8'h01);
        @(negedge clk);
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_outs", outs(), {13'd0, 8'h00, 8'h00, 3'b110});
        @(posedge clk); #1;

        issue(3'd1, 8'h7F, 8'hFF);
        @(negedge clk);
        check("sub_outs", outs(), {13'd0, 8'h00, 8'h80, 3'b011});
        @(posedge clk); #1;

        issue(3'd7, 8'hFE, 8'h01);
        @(negedge clk);
        check("slt_res", 32'(result), 32'h01);
        @(posedge clk); #1;

        // Back-to-back stream: ADD, XOR, NAND, OR
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            opcode = (i == 0) ? 3'd0 : (i == 1) ? 3'd6 : (i == 2) ? 3'd3 : 3'd5;
            op1 = rnd_op(); op2 = rnd_op();
            @(negedge clk);
            check("stream_in_ready", 32'(in_ready), 32'd1);
            if (i > 0) check("stream_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("stream_last_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("stream_drained", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // MUL FF*FF: 9 cycles with in_ready low, then the product
        issue(3'd2, 8'hFF, 8'hFF);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 40) begin
            check("mul_in_ready_low", 32'(in_ready), 32'd0);
            n++;
            @(negedge clk);
        end
        check("mul_latency", 32'(n), 32'd9);
        check("mul_outs", outs(), {13'd0, 8'hFE, 8'h01, 3'b000});
        @(posedge clk); #1;

        // Backpressure: held ADD result blocks a MUL
        out_ready = 1'b0;
        issue(3'd0, 8'h10, 8'h20);
        in_valid = 1'b1; opcode = 3'd2; op1 = 8'h03; op2 = 8'h05;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold", {31'd0, out_valid} << 19 | outs(), (32'd1 << 19) | {13'd0, 8'h00, 8'h30, 3'b000});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        // Product must appear and stay put while the consumer stalls
        repeat (12) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mul_hold", {31'd0, out_valid} << 19 | outs(), (32'd1 << 19) | {13'd0, 8'h00, 8'h0F, 3'b000});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Reset mid-MUL
        issue(3'd2, 8'h12, 8'h34);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midmul_rst_outs", {31'd0, out_valid} << 19 | outs(), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        check("midmul_in_ready", 32'(in_ready), 32'd1);
        issue(3'd4, 8'hF0, 8'h3C);
        @(negedge clk);
        check("post_rst_and", 32'(result), 32'h30);
        @(posedge clk); #1;

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            opcode    = 3'($urandom_range(0, 7));
            op1       = rnd_op();
            op2       = rnd_op();
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_queue", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
